// File: rtl/param_deserializer_pkg.sv
// Shared types for the parametrised serial deserializer: FSM states,
// the per-frame result word, and the bit-counter width helper.
package param_deserializer_pkg;

    // Widest payload the result word can carry. Instances use the low
    // DATA_W bits and leave the rest at zero.
    localparam int MAX_DATA_W = 64;
    localparam int MAX_LEN_W  = $clog2(MAX_DATA_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_DATA_W-1:0] mask;
        logic [MAX_LEN_W-1:0]  len;
        logic                  err_preamb;
        logic                  err_parity;
        logic                  err_len;
    } result_t;

    // Bit counter must reach preamble + payload + 2 without wrapping.
    function automatic int cnt_w(input int preamb_w, input int data_w);
        return $clog2(preamb_w + data_w + 3);
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Valid/ready holding register for decoded frames. A frame arriving while
// a word is held and not being taken is discarded and counted.
module deser_out_reg
    import param_deserializer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic       ready_i,
    input  result_t    res_i,
    output logic       valid_o,
    output result_t    res_o,
    output logic [7:0] drop_cnt_o
);

    logic       valid_q, valid_d;
    result_t    res_q, res_d;
    logic [7:0] drop_q, drop_d;
    logic       accept;

    // Load when the slot is free or being emptied on this edge; otherwise drop.
    always_comb begin
        accept  = load_i && (!valid_q || ready_i);
        valid_d = valid_q;
        res_d   = res_q;
        drop_d  = drop_q;
        if (accept) begin
            valid_d = 1'b1;
            res_d   = res_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i && !accept && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Holding register and saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o    = valid_q;
    assign res_o      = res_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: rtl/param_deserializer.sv
// Frames serial bits under an enable strobe, checks the preamble, recovers
// a variable-length payload with optional parity, and hands one result
// word per frame to a valid/ready output register.
module param_deserializer
    import param_deserializer_pkg::*;
#(
    parameter int                  DATA_W     = 10,
    parameter int                  PREAMB_W   = 4,
    parameter logic [PREAMB_W-1:0] PREAMB     = 4'b1010,
    parameter int                  PARITY_EN  = 1,
    parameter int                  PARITY_ODD = 0,
    parameter int                  MSB_FIRST  = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        ser_data_i,
    input  logic                        ser_data_en_i,
    output logic [DATA_W-1:0]           data_o,
    output logic [DATA_W-1:0]           mask_o,
    output logic [$clog2(DATA_W+1)-1:0] len_o,
    output logic                        err_preamb_o,
    output logic                        err_parity_o,
    output logic                        err_len_o,
    output logic                        err_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [7:0]                  drop_cnt_o
);

    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int CNT_W = cnt_w(PREAMB_W, DATA_W);
    localparam int N_MAX = PREAMB_W + DATA_W + 2;
    // Payload window plus a slot for the trailing parity bit.
    localparam int WIN_W = DATA_W + PARITY_EN;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [PREAMB_W-1:0] preamb_q, preamb_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic                par_q, par_d;

    logic                start;
    logic                eof;
    logic [CNT_W-1:0]    pos;
    logic [WIN_W-1:0]    data_src;
    int                  l_int;
    result_t             res_in, res_out;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: a frame lasts exactly as long as the enable strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ser_data_en_i)  state_d = RECV;
            RECV:    if (!ser_data_en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: frame start (first bit is captured on this edge) and EOF.
    always_comb begin
        start = 1'b0;
        eof   = 1'b0;
        case (state_q)
            IDLE:    start = ser_data_en_i;
            RECV:    eof   = !ser_data_en_i;
            default: ;
        endcase
    end

    // Bit capture: preamble shift, payload window, running parity, counter.
    always_comb begin
        n_d      = n_q;
        preamb_d = preamb_q;
        win_d    = win_q;
        par_d    = par_q;
        pos      = start ? '0 : n_q;
        if (start) begin
            n_d      = '0;
            preamb_d = '0;
            win_d    = '0;
            par_d    = 1'b0;
        end
        if (ser_data_en_i) begin
            if (pos != CNT_W'(N_MAX)) n_d = pos + CNT_W'(1);
            if (int'(pos) < PREAMB_W) begin
                preamb_d = (preamb_d << 1) | PREAMB_W'(ser_data_i);
            end else begin
                par_d = par_d ^ ser_data_i;
                if (MSB_FIRST != 0) begin
                    // Newest bit at bit 0; the window keeps the most recent bits.
                    win_d = (win_d << 1) | WIN_W'(ser_data_i);
                end else begin
                    // Bit k of the payload goes straight to position k; bits
                    // past the window are ignored so the first ones survive.
                    for (int i = 0; i < WIN_W; i++) begin
                        if (i == int'(pos) - PREAMB_W) win_d[i] = ser_data_i;
                    end
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            n_q      <= '0;
            preamb_q <= '0;
            win_q    <= '0;
            par_q    <= 1'b0;
        end else begin
            n_q      <= n_d;
            preamb_q <= preamb_d;
            win_q    <= win_d;
            par_q    <= par_d;
        end
    end

    // Result word from the captured state; only consumed on the EOF edge.
    always_comb begin
        l_int = int'(n_q) - PREAMB_W - PARITY_EN;
        if (l_int < 0) l_int = 0;
        // With MSB-first the parity bit sits at the bottom of the window.
        data_src = (MSB_FIRST != 0) ? (win_q >> PARITY_EN) : win_q;
        res_in   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            res_in.mask[i] = (i < l_int);
            res_in.data[i] = data_src[i] && (i < l_int);
        end
        res_in.len        = MAX_LEN_W'((l_int > DATA_W) ? DATA_W : l_int);
        res_in.err_preamb = (int'(n_q) < PREAMB_W) || (preamb_q != PREAMB);
        res_in.err_len    = (l_int == 0) || (l_int > DATA_W);
        res_in.err_parity = (PARITY_EN != 0) && (l_int >= 1) &&
                            (par_q != (PARITY_ODD != 0));
    end

    deser_out_reg u_out (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (eof),
        .ready_i    (ready_i),
        .res_i      (res_in),
        .valid_o    (valid_o),
        .res_o      (res_out),
        .drop_cnt_o (drop_cnt_o)
    );

    assign data_o       = res_out.data[DATA_W-1:0];
    assign mask_o       = res_out.mask[DATA_W-1:0];
    assign len_o        = res_out.len[LEN_W-1:0];
    assign err_preamb_o = res_out.err_preamb;
    assign err_parity_o = res_out.err_parity;
    assign err_len_o    = res_out.err_len;
    assign err_o        = res_out.err_preamb | res_out.err_parity | res_out.err_len;

    // Upper bits of the wide result word are always zero for this instance.
    logic [2*MAX_DATA_W+MAX_LEN_W-1:0] res_unused;
    assign res_unused = {res_out.data, res_out.mask, res_out.len};

endmodule

// File: tb/tb_param_deserializer.sv
// Bench for param_deserializer: two instances (MSB-first and LSB-first)
// share the serial line and ready; a reference model fills one scoreboard
// queue per instance as frames are driven.
module tb_param_deserializer;

    typedef struct packed {
        logic       valid;
        logic [9:0] data;
        logic [9:0] mask;
        logic [3:0] len;
        logic       ep;
        logic       epar;
        logic       el;
        logic       e;
    } word_t;

    logic clk, rst_n, ser_d, ser_en, ready;
    logic [9:0] data_a, mask_a, data_b, mask_b;
    logic [3:0] len_a, len_b;
    logic ep_a, epar_a, el_a, e_a, valid_a;
    logic ep_b, epar_b, el_b, e_b, valid_b;
    logic [7:0] drop_a, drop_b;

    int n_cmp = 0;
    int n_bad = 0;
    word_t q_a[$];
    word_t q_b[$];

    param_deserializer u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .ser_data_i(ser_d), .ser_data_en_i(ser_en),
        .data_o(data_a), .mask_o(mask_a), .len_o(len_a),
        .err_preamb_o(ep_a), .err_parity_o(epar_a), .err_len_o(el_a), .err_o(e_a),
        .valid_o(valid_a), .ready_i(ready), .drop_cnt_o(drop_a)
    );

    param_deserializer #(.MSB_FIRST(0)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .ser_data_i(ser_d), .ser_data_en_i(ser_en),
        .data_o(data_b), .mask_o(mask_b), .len_o(len_b),
        .err_preamb_o(ep_b), .err_parity_o(epar_b), .err_len_o(el_b), .err_o(e_b),
        .valid_o(valid_b), .ready_i(ready), .drop_cnt_o(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t obs_a();
        return {valid_a, data_a, mask_a, len_a, ep_a, epar_a, el_a, e_a};
    endfunction

    function automatic word_t obs_b();
        return {valid_b, data_b, mask_b, len_b, ep_b, epar_b, el_b, e_b};
    endfunction

    // Reference decode for the default 4-bit 1010 preamble, 10-bit payload, even parity.
    function automatic word_t model(input logic [31:0] f, input int nb, input bit msb);
        word_t w;
        logic pay[$];
        logic p, b;
        logic [31:0] t;
        logic [3:0] pre;
        int n, l, lt;
        w = '0; p = 1'b0; pre = '0;
        for (int k = 0; k < nb; k++) begin
            t = f >> (nb - 1 - k);
            b = t[0];
            if (k < 4) pre = {pre[2:0], b};
            else begin p = p ^ b; pay.push_back(b); end
        end
        if (pay.size() > 0) pay.delete(pay.size() - 1);
        lt = pay.size();
        n = (nb > 16) ? 16 : nb;
        l = n - 5;
        if (l < 0) l = 0;
        w.valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w.mask[i] = (i < l);
            if (i < lt && i < l) w.data[i] = msb ? pay[lt - 1 - i] : pay[i];
        end
        w.len  = 4'((l > 10) ? 10 : l);
        w.ep   = (nb < 4) || (pre != 4'b1010);
        w.el   = (l == 0) || (l > 10);
        w.epar = (l >= 1) && p;
        w.e    = w.ep | w.epar | w.el;
        return w;
    endfunction

    // Drive one frame from a negedge; returns on the negedge after the EOF edge.
    task automatic send_frame(input logic [31:0] f, input int nb, input bit rdy_eof);
        logic [31:0] t;
        for (int k = 0; k < nb; k++) begin
            t = f >> (nb - 1 - k);
            ser_en = 1'b1;
            ser_d  = t[0];
            @(negedge clk);
        end
        ser_en = 1'b0;
        ser_d  = 1'b0;
        if (rdy_eof) ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [31:0] f, input int nb);
        q_a.push_back(model(f, nb, 1'b1));
        q_b.push_back(model(f, nb, 1'b0));
    endtask

    task automatic test_reset();
        n_cmp++;
        if (obs_a() !== '0) begin n_bad++; $display("FAIL reset_word_a: got %h want 0", obs_a()); end
        n_cmp++;
        if (obs_b() !== '0) begin n_bad++; $display("FAIL reset_word_b: got %h want 0", obs_b()); end
        n_cmp++;
        if (drop_a !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_a); end
    endtask

    task automatic test_full_frame();
        logic [31:0] f, t;
        word_t e;
        f = 32'({4'b1010, 10'b1011001110, 1'b0});
        push_frame(f, 15);
        for (int k = 0; k < 15; k++) begin
            t = f >> (14 - k);
            ser_en = 1'b1; ser_d = t[0];
            @(negedge clk);
        end
        ser_en = 1'b0; ser_d = 1'b0;
        n_cmp++;
        if (valid_a !== 1'b0) begin n_bad++; $display("FAIL full_early_valid: got %b want 0", valid_a); end
        @(negedge clk);
        n_cmp++;
        if (obs_a() !== {1'b1, 10'b1011001110, 10'h3FF, 4'd10, 4'b0000}) begin
            n_bad++; $display("FAIL full_const_a: got %h want %h", obs_a(),
                              {1'b1, 10'b1011001110, 10'h3FF, 4'd10, 4'b0000});
        end
        e = q_a.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_bad++; $display("FAIL full_a: got %h want %h", obs_a(), e); end
        e = q_b.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_bad++; $display("FAIL full_b: got %h want %h", obs_b(), e); end
    endtask

    // Two short frames separated by a single low cycle; second has bad parity.
    task automatic test_back_to_back();
        word_t e;
        push_frame(32'({4'b1010, 3'b101, 1'b0}), 8);
        send_frame(32'({4'b1010, 3'b101, 1'b0}), 8, 1'b0);
        e = q_a.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_bad++; $display("FAIL short_a: got %h want %h", obs_a(), e); end
        e = q_b.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_bad++; $display("FAIL short_b: got %h want %h", obs_b(), e); end
        push_frame(32'({4'b1010, 3'b101, 1'b1}), 8);
        send_frame(32'({4'b1010, 3'b101, 1'b1}), 8, 1'b0);
        e = q_a.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_bad++; $display("FAIL parity_a: got %h want %h", obs_a(), e); end
        n_cmp++;
        if (epar_a !== 1'b1) begin n_bad++; $display("FAIL parity_flag: got %b want 1", epar_a); end
        e = q_b.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_bad++; $display("FAIL parity_b: got %h want %h", obs_b(), e); end
    endtask

    task automatic test_errors();
        word_t e;
        push_frame(32'({4'b1110, 10'b0, 1'b0}), 15);
        send_frame(32'({4'b1110, 10'b0, 1'b0}), 15, 1'b0);
        e = q_a.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_bad++; $display("FAIL bad_preamb_a: got %h want %h", obs_a(), e); end
        e = q_b.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_bad++; $display("FAIL bad_preamb_b: got %h want %h", obs_b(), e); end
        push_frame(32'(3'b101), 3);
        send_frame(32'(3'b101), 3, 1'b0);
        e = q_a.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_bad++; $display("FAIL short3_a: got %h want %h", obs_a(), e); end
        n_cmp++;
        if ({ep_a, el_a} !== 2'b11) begin n_bad++; $display("FAIL short3_flags: got %b want 11", {ep_a, el_a}); end
        e = q_b.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_bad++; $display("FAIL short3_b: got %h want %h", obs_b(), e); end
    endtask

    task automatic test_long_payload();
        word_t e;
        push_frame(32'({4'b1010, 14'b10110011100101, 1'b0}), 19);
        send_frame(32'({4'b1010, 14'b10110011100101, 1'b0}), 19, 1'b0);
        e = q_a.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_bad++; $display("FAIL long_a: got %h want %h", obs_a(), e); end
        e = q_b.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_bad++; $display("FAIL long_b: got %h want %h", obs_b(), e); end
        n_cmp++;
        if (data_b !== 10'b0111001101) begin n_bad++; $display("FAIL long_first10: got %b want 0111001101", data_b); end
    endtask

    task automatic test_backpressure();
        word_t e;
        @(negedge clk);
        ready = 1'b0;
        push_frame(32'({4'b1010, 2'b10, 1'b1}), 7);
        send_frame(32'({4'b1010, 2'b10, 1'b1}), 7, 1'b0);
        n_cmp++;
        if (obs_a() !== q_a[0]) begin n_bad++; $display("FAIL bp_first_a: got %h want %h", obs_a(), q_a[0]); end
        send_frame(32'({4'b1010, 5'b11100, 1'b1}), 10, 1'b0);
        n_cmp++;
        if (obs_a() !== q_a[0]) begin n_bad++; $display("FAIL bp_hold1_a: got %h want %h", obs_a(), q_a[0]); end
        send_frame(32'({4'b0101, 6'b000111, 1'b0}), 11, 1'b0);
        n_cmp++;
        if (obs_b() !== q_b[0]) begin n_bad++; $display("FAIL bp_hold2_b: got %h want %h", obs_b(), q_b[0]); end
        n_cmp++;
        if (drop_a !== 8'd2) begin n_bad++; $display("FAIL bp_drop_a: got %0d want 2", drop_a); end
        n_cmp++;
        if (drop_b !== 8'd2) begin n_bad++; $display("FAIL bp_drop_b: got %0d want 2", drop_b); end
        push_frame(32'({4'b1010, 4'b1001, 1'b0}), 9);
        send_frame(32'({4'b1010, 4'b1001, 1'b0}), 9, 1'b1);
        e = q_a.pop_front(); e = q_a.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_bad++; $display("FAIL bp_swap_a: got %h want %h", obs_a(), e); end
        e = q_b.pop_front(); e = q_b.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_bad++; $display("FAIL bp_swap_b: got %h want %h", obs_b(), e); end
    endtask

    task automatic test_reset_mid_frame();
        word_t e;
        logic [31:0] t;
        @(negedge clk);
        ready = 1'b0;
        send_frame(32'({4'b1010, 3'b011, 1'b0}), 8, 1'b0);
        for (int k = 0; k < 6; k++) begin
            t = 32'(6'b101011) >> (5 - k);
            ser_en = 1'b1; ser_d = t[0];
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_a() !== '0) begin n_bad++; $display("FAIL midrst_a: got %h want 0", obs_a()); end
        n_cmp++;
        if (obs_b() !== '0) begin n_bad++; $display("FAIL midrst_b: got %h want 0", obs_b()); end
        n_cmp++;
        if (drop_a !== 8'd0) begin n_bad++; $display("FAIL midrst_drop: got %0d want 0", drop_a); end
        ser_en = 1'b0; ser_d = 1'b0; ready = 1'b1;
        q_a.delete(); q_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame(32'({4'b1010, 10'b1100110011, 1'b0}), 15);
        send_frame(32'({4'b1010, 10'b1100110011, 1'b0}), 15, 1'b0);
        e = q_a.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_bad++; $display("FAIL post_rst_a: got %h want %h", obs_a(), e); end
        e = q_b.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_bad++; $display("FAIL post_rst_b: got %h want %h", obs_b(), e); end
    endtask

    initial begin
        rst_n = 1'b0; ser_d = 1'b0; ser_en = 1'b0; ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_full_frame();
        test_back_to_back();
        test_errors();
        test_long_payload();
        test_backpressure();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
